mc_main_ctrl: RTL and testbench
===============================

Name: mc_main_ctrl

Overview:
- Multi-cycle main control FSM for the MIPS datapath. It sits directly upstream of the ALU controller.
- Decodes op_i and sequences the per-cycle datapath enables.
- Drives the 3-bit ALUOp code consumed by the ALU controller:
  - 000: R-type, use funct
  - 010: add
  - 110: subtract/branch
  - 111: set-less-than
- Adds memory-ready wait states with a timeout fault.

Parameters:
MEM_WAIT_MAX, 15, max consecutive cycles a memory state waits with mem_ready_i low before fault; 0 disables the timeout.
WAIT_W, 8, wait counter width; MEM_WAIT_MAX must be < 2**WAIT_W.

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  asynchronous active-high reset
op_i  input  6  opcode field of IR, sampled in DECODE and MEMADR
mem_ready_i  input  1  memory access completes this cycle
ALUOp_o  output  3  ALU operation class to ALU controller
ALUSrcA_o  output  1  0=PC, 1=rs
ALUSrcB_o  output  2  00=rt, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
PCSource_o  output  2  00=ALU result, 01=ALUOut, 10=jump target
PCWrite_o  output  1  unconditional PC write
PCWriteCond_o  output  1  PC write if ALU zero
IorD_o  output  1  memory address 0=PC, 1=ALUOut
MemRead_o  output  1  memory read strobe
MemWrite_o  output  1  memory write strobe
IRWrite_o  output  1  instruction register load
RegWrite_o  output  1  register file write
RegDst_o  output  1  0=rt, 1=rd
MemtoReg_o  output  1  0=ALUOut, 1=MDR
illegal_o  output  1  sticky unsupported-opcode flag
mem_fault_o  output  1  sticky memory timeout flag
state_o  output  4  current state encoding, debug

Behaviour:
- Reset (async, active-high): state=FETCH, wait counter=0, all outputs 0 while rst_i is high. Outputs follow state decode from the first edge after release.
- Moore outputs decode state only, except IRWrite_o/PCWrite_o in FETCH. Unlisted outputs are 0.
- State encodings, per-state outputs and next state:
  - FETCH=0: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=010, PCSource=00; IRWrite=PCWrite=mem_ready_i. Stay until mem_ready_i, then DECODE.
  - DECODE=1: ALUSrcA=0, ALUSrcB=11, ALUOp=010. Next by op_i:
    - 000000 -> EXEC
    - 100011/101011 -> MEMADR
    - 000100 -> BRANCH
    - 001000 -> ADDI_EX
    - 001010 -> SLTI_EX
    - 000010 -> JUMP
    - others -> ILLEGAL
  - MEMADR=2: ALUSrcA=1, ALUSrcB=10, ALUOp=010. lw -> MEMRD, sw -> MEMWR.
  - MEMRD=3: MemRead=1, IorD=1. Wait for mem_ready_i, then MEMWB.
  - MEMWB=4: RegWrite=1, MemtoReg=1, RegDst=0. -> FETCH.
  - MEMWR=5: MemWrite=1, IorD=1. Wait for mem_ready_i, then FETCH.
  - EXEC=6: ALUSrcA=1, ALUSrcB=00, ALUOp=000. -> RWB.
  - RWB=7: RegWrite=1, RegDst=1. -> FETCH.
  - BRANCH=8: ALUSrcA=1, ALUSrcB=00, ALUOp=110, PCWriteCond=1, PCSource=01. -> FETCH.
  - ADDI_EX=9: ALUSrcA=1, ALUSrcB=10, ALUOp=010. -> IWB.
  - SLTI_EX=10: as ADDI_EX but ALUOp=111. -> IWB.
  - IWB=11: RegWrite=1, RegDst=0, MemtoReg=0. -> FETCH.
  - JUMP=12: PCWrite=1, PCSource=10. -> FETCH.
  - ILLEGAL=13: illegal_o=1. All enables 0. Terminal until reset.
  - FAULT=14: mem_fault_o=1. All enables 0. Terminal until reset.
- ALUOp codes 001/011/100/101 are never emitted.
- Latencies with mem_ready_i tied high:
  - R-type, addi, slti, sw: 4 cycles
  - lw: 5 cycles
  - beq, j: 3 cycles
- Wait counter rules:
  - Cleared on every entry to FETCH/MEMRD/MEMWR.
  - Increments each cycle spent in one of those states with mem_ready_i=0.
  - If mem_ready_i=0 and counter==MEM_WAIT_MAX-1, next state is FAULT. The wait therefore lasts at most MEM_WAIT_MAX low cycles.
  - mem_ready_i=1 on that same cycle wins: normal transition, no fault.
  - With MEM_WAIT_MAX=0 the counter saturates at all-ones and never faults.
- Reset asserted mid-instruction aborts immediately. No strobe persists past the asserting edge.

Optional Feature:
- Macro: MC_MAIN_CTRL_BNE_EN.
- Defined:
  - Adds output branch_ne_o (1 bit).
  - op_i=000101 in DECODE -> BRANCH_NE=15.
  - BRANCH_NE outputs: BRANCH outputs plus branch_ne_o=1, so the datapath inverts zero for the PCWriteCond qualification. -> FETCH.
- Undefined:
  - No branch_ne_o port.
  - 000101 -> ILLEGAL.
  - Encoding 15 is unreachable.

Test Plan:
- Reset then op_i=000000, mem_ready_i=1 -> state_o 0,1,6,7,0. ALUOp_o=000 in EXEC. RegWrite_o=1 and RegDst_o=1 in RWB.
- op_i=001010 (slti), ready high -> state_o 0,1,10,11,0. ALUOp_o=111 in SLTI_EX. ALUSrcB_o=10.
- op_i=100011 (lw), ready low 3 cycles in MEMRD -> MEMRD held 4 cycles with MemRead_o=1 and IorD_o=1. Then MEMWB with MemtoReg_o=1.
- MEM_WAIT_MAX=15, ready held low in FETCH -> FAULT after 15 cycles. mem_fault_o=1 sticky. Rerun with ready=1 on cycle 15 -> DECODE, no fault.
- op_i=111111 -> ILLEGAL (13). illegal_o=1. All strobes 0. rst_i pulse -> FETCH, flag cleared.
- rst_i asserted asynchronously mid-MEMWR (MemWrite_o=1) -> MemWrite_o drops without a clock edge. state_o=0.

Source files
------------

// File: rtl/mc_main_ctrl.sv
// Multi-cycle MIPS main control FSM with memory-ready wait states and timeout fault.
// Optional bne support is enabled by defining MC_MAIN_CTRL_BNE_EN.
module mc_main_ctrl #(
    parameter int MEM_WAIT_MAX = 15,
    parameter int WAIT_W       = 8
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [5:0] op_i,
    input  logic       mem_ready_i,
    output logic [2:0] ALUOp_o,
    output logic       ALUSrcA_o,
    output logic [1:0] ALUSrcB_o,
    output logic [1:0] PCSource_o,
    output logic       PCWrite_o,
    output logic       PCWriteCond_o,
    output logic       IorD_o,
    output logic       MemRead_o,
    output logic       MemWrite_o,
    output logic       IRWrite_o,
    output logic       RegWrite_o,
    output logic       RegDst_o,
    output logic       MemtoReg_o,
    output logic       illegal_o,
    output logic       mem_fault_o,
`ifdef MC_MAIN_CTRL_BNE_EN
    output logic       branch_ne_o,
`endif
    output logic [3:0] state_o
);

    localparam logic [3:0] S_FETCH   = 4'd0;
    localparam logic [3:0] S_DECODE  = 4'd1;
    localparam logic [3:0] S_MEMADR  = 4'd2;
    localparam logic [3:0] S_MEMRD   = 4'd3;
    localparam logic [3:0] S_MEMWB   = 4'd4;
    localparam logic [3:0] S_MEMWR   = 4'd5;
    localparam logic [3:0] S_EXEC    = 4'd6;
    localparam logic [3:0] S_RWB     = 4'd7;
    localparam logic [3:0] S_BRANCH  = 4'd8;
    localparam logic [3:0] S_ADDI    = 4'd9;
    localparam logic [3:0] S_SLTI    = 4'd10;
    localparam logic [3:0] S_IWB     = 4'd11;
    localparam logic [3:0] S_JUMP    = 4'd12;
    localparam logic [3:0] S_ILLEGAL = 4'd13;
    localparam logic [3:0] S_FAULT   = 4'd14;
    localparam logic [3:0] S_BNE     = 4'd15;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [WAIT_W-1:0] LP_WAIT_LAST = WAIT_W'(MEM_WAIT_MAX - 1);

    logic [3:0]        r_state;
    logic [3:0]        w_next;
    logic [WAIT_W-1:0] r_wait;
    logic              r_run;
    logic              w_mem_st;
    logic              w_timeout;

    assign w_mem_st  = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
    assign w_timeout = (MEM_WAIT_MAX != 0) && w_mem_st && !mem_ready_i && (r_wait == LP_WAIT_LAST);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:  w_next = mem_ready_i ? S_DECODE : (w_timeout ? S_FAULT : S_FETCH);
            S_DECODE: begin
                case (op_i)
                    OP_RTYPE:      w_next = S_EXEC;
                    OP_LW, OP_SW:  w_next = S_MEMADR;
                    OP_BEQ:        w_next = S_BRANCH;
                    OP_ADDI:       w_next = S_ADDI;
                    OP_SLTI:       w_next = S_SLTI;
                    OP_J:          w_next = S_JUMP;
`ifdef MC_MAIN_CTRL_BNE_EN
                    OP_BNE:        w_next = S_BNE;
`endif
                    default:       w_next = S_ILLEGAL;
                endcase
            end
            // op_i is re-sampled here; anything but lw/sw is treated as unsupported
            S_MEMADR: w_next = (op_i == OP_LW) ? S_MEMRD : ((op_i == OP_SW) ? S_MEMWR : S_ILLEGAL);
            S_MEMRD:  w_next = mem_ready_i ? S_MEMWB : (w_timeout ? S_FAULT : S_MEMRD);
            S_MEMWB:  w_next = S_FETCH;
            S_MEMWR:  w_next = mem_ready_i ? S_FETCH : (w_timeout ? S_FAULT : S_MEMWR);
            S_EXEC:   w_next = S_RWB;
            S_RWB:    w_next = S_FETCH;
            S_BRANCH: w_next = S_FETCH;
            S_ADDI:   w_next = S_IWB;
            S_SLTI:   w_next = S_IWB;
            S_IWB:    w_next = S_FETCH;
            S_JUMP:   w_next = S_FETCH;
`ifdef MC_MAIN_CTRL_BNE_EN
            S_BNE:    w_next = S_FETCH;
`endif
            default:  w_next = r_state;
        endcase
    end

    // r_run holds the FSM and blanks outputs until the first edge after reset release
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_run   <= 1'b0;
            r_state <= S_FETCH;
            r_wait  <= '0;
        end else if (!r_run) begin
            r_run <= 1'b1;
        end else begin
            r_state <= w_next;
            if (w_mem_st && !mem_ready_i && (w_next == r_state))
                r_wait <= (r_wait == '1) ? r_wait : r_wait + 1'b1;
            else
                r_wait <= '0;
        end
    end

    always_comb begin
        ALUOp_o       = 3'b000;
        ALUSrcA_o     = 1'b0;
        ALUSrcB_o     = 2'b00;
        PCSource_o    = 2'b00;
        PCWrite_o     = 1'b0;
        PCWriteCond_o = 1'b0;
        IorD_o        = 1'b0;
        MemRead_o     = 1'b0;
        MemWrite_o    = 1'b0;
        IRWrite_o     = 1'b0;
        RegWrite_o    = 1'b0;
        RegDst_o      = 1'b0;
        MemtoReg_o    = 1'b0;
        illegal_o     = 1'b0;
        mem_fault_o   = 1'b0;
`ifdef MC_MAIN_CTRL_BNE_EN
        branch_ne_o   = 1'b0;
`endif
        if (r_run) begin
            case (r_state)
                S_FETCH: begin
                    MemRead_o = 1'b1;
                    ALUSrcB_o = 2'b01;
                    ALUOp_o   = 3'b010;
                    IRWrite_o = mem_ready_i;
                    PCWrite_o = mem_ready_i;
                end
                S_DECODE: begin
                    ALUSrcB_o = 2'b11;
                    ALUOp_o   = 3'b010;
                end
                S_MEMADR, S_ADDI: begin
                    ALUSrcA_o = 1'b1;
                    ALUSrcB_o = 2'b10;
                    ALUOp_o   = 3'b010;
                end
                S_SLTI: begin
                    ALUSrcA_o = 1'b1;
                    ALUSrcB_o = 2'b10;
                    ALUOp_o   = 3'b111;
                end
                S_MEMRD: begin
                    MemRead_o = 1'b1;
                    IorD_o    = 1'b1;
                end
                S_MEMWB: begin
                    RegWrite_o = 1'b1;
                    MemtoReg_o = 1'b1;
                end
                S_MEMWR: begin
                    MemWrite_o = 1'b1;
                    IorD_o     = 1'b1;
                end
                S_EXEC:  ALUSrcA_o = 1'b1;
                S_RWB: begin
                    RegWrite_o = 1'b1;
                    RegDst_o   = 1'b1;
                end
                S_BRANCH: begin
                    ALUSrcA_o     = 1'b1;
                    ALUOp_o       = 3'b110;
                    PCWriteCond_o = 1'b1;
                    PCSource_o    = 2'b01;
                end
`ifdef MC_MAIN_CTRL_BNE_EN
                S_BNE: begin
                    ALUSrcA_o     = 1'b1;
                    ALUOp_o       = 3'b110;
                    PCWriteCond_o = 1'b1;
                    PCSource_o    = 2'b01;
                    branch_ne_o   = 1'b1;
                end
`endif
                S_IWB:     RegWrite_o = 1'b1;
                S_JUMP: begin
                    PCWrite_o  = 1'b1;
                    PCSource_o = 2'b10;
                end
                S_ILLEGAL: illegal_o   = 1'b1;
                S_FAULT:   mem_fault_o = 1'b1;
                default: ;
            endcase
        end
    end

    assign state_o = r_state;

endmodule

// File: tb/tb_mc_main_ctrl.sv
// Directed bench for mc_main_ctrl: per-cycle expected output vectors go through a scoreboard queue.
module tb_mc_main_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] op;
    logic       rdy;
    logic [2:0] ALUOp;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] PCSource;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       RegWrite, RegDst, MemtoReg, illegal, mem_fault;
    logic [3:0] state;
`ifdef MC_MAIN_CTRL_BNE_EN
    logic       branch_ne;
`endif

    int n_chk  = 0;
    int n_fail = 0;
    logic [22:0] exp_q[$];

    always #5 clk = ~clk;

    mc_main_ctrl #(.MEM_WAIT_MAX(15), .WAIT_W(8)) dut (
        .clk_i(clk), .rst_i(rst), .op_i(op), .mem_ready_i(rdy),
        .ALUOp_o(ALUOp), .ALUSrcA_o(ALUSrcA), .ALUSrcB_o(ALUSrcB), .PCSource_o(PCSource),
        .PCWrite_o(PCWrite), .PCWriteCond_o(PCWriteCond), .IorD_o(IorD),
        .MemRead_o(MemRead), .MemWrite_o(MemWrite), .IRWrite_o(IRWrite),
        .RegWrite_o(RegWrite), .RegDst_o(RegDst), .MemtoReg_o(MemtoReg),
        .illegal_o(illegal), .mem_fault_o(mem_fault),
`ifdef MC_MAIN_CTRL_BNE_EN
        .branch_ne_o(branch_ne),
`endif
        .state_o(state)
    );

    wire [22:0] obs = {state, ALUOp, ALUSrcA, ALUSrcB, PCSource, PCWrite, PCWriteCond, IorD,
                       MemRead, MemWrite, IRWrite, RegWrite, RegDst, MemtoReg, illegal, mem_fault};

    // Expected outputs for a state, straight from the per-state output table
    function automatic logic [22:0] exp_vec(input logic [3:0] st, input logic r);
        logic [2:0] aop;
        logic       sa, pcw, pcwc, iod, mr, mw, irw, rw, rd, m2r, ill, flt;
        logic [1:0] sb, pcs;
        {aop, sa, sb, pcs, pcw, pcwc, iod, mr, mw, irw, rw, rd, m2r, ill, flt} = '0;
        case (st)
            4'd0:  begin mr = 1; sb = 2'b01; aop = 3'b010; irw = r; pcw = r; end
            4'd1:  begin sb = 2'b11; aop = 3'b010; end
            4'd2:  begin sa = 1; sb = 2'b10; aop = 3'b010; end
            4'd3:  begin mr = 1; iod = 1; end
            4'd4:  begin rw = 1; m2r = 1; end
            4'd5:  begin mw = 1; iod = 1; end
            4'd6:  begin sa = 1; end
            4'd7:  begin rw = 1; rd = 1; end
            4'd8:  begin sa = 1; aop = 3'b110; pcwc = 1; pcs = 2'b01; end
            4'd9:  begin sa = 1; sb = 2'b10; aop = 3'b010; end
            4'd10: begin sa = 1; sb = 2'b10; aop = 3'b111; end
            4'd11: begin rw = 1; end
            4'd12: begin pcw = 1; pcs = 2'b10; end
            4'd13: begin ill = 1; end
            4'd14: begin flt = 1; end
            4'd15: begin sa = 1; aop = 3'b110; pcwc = 1; pcs = 2'b01; end
            default: ;
        endcase
        return {st, aop, sa, sb, pcs, pcw, pcwc, iod, mr, mw, irw, rw, rd, m2r, ill, flt};
    endfunction

    task automatic check(input string tag, input logic [22:0] o, input logic [22:0] e);
        n_chk++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    // Called at a negedge: drive inputs, queue the expectation, compare, advance one cycle
    task automatic cyc(input string tag, input logic [5:0] o, input logic r, input logic [3:0] st);
        logic [22:0] e;
        op  = o;
        rdy = r;
        exp_q.push_back(exp_vec(st, r));
        #1;
        if (exp_q.size() == 0) begin
            n_chk++; n_fail++;
            $error("FAIL %s scoreboard empty observed=%h expected=entry", tag, obs);
        end else begin
            e = exp_q.pop_front();
            check(tag, obs, e);
        end
        @(negedge clk);
    endtask

    // Async reset mid-cycle; outputs must drop with no clock edge, then resync
    task automatic rst_pulse(input string tag);
        #2 rst = 1'b1;
        #1 check({tag, "_async"}, obs, 23'd0);
        check({tag, "_memwrite"}, {22'd0, MemWrite}, 23'd0);
        @(negedge clk);
        rst = 1'b0;
        #1 check({tag, "_prerun"}, obs, 23'd0);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; op = 6'd0; rdy = 1'b0;
        @(negedge clk);
        #1 check("reset", obs, 23'd0);
        @(negedge clk);
        rst = 1'b0;
        #1 check("prerun", obs, 23'd0);
        @(negedge clk);

        // R-type
        cyc("r_fetch", 6'b000000, 1, 4'd0);
        cyc("r_decode", 6'b000000, 1, 4'd1);
        cyc("r_exec", 6'b000000, 1, 4'd6);
        cyc("r_rwb", 6'b000000, 1, 4'd7);
        // slti
        cyc("slti_fetch", 6'b001010, 1, 4'd0);
        cyc("slti_decode", 6'b001010, 1, 4'd1);
        cyc("slti_ex", 6'b001010, 1, 4'd10);
        cyc("slti_iwb", 6'b001010, 1, 4'd11);
        // lw with three wait cycles in MEMRD
        cyc("lw_fetch", 6'b100011, 1, 4'd0);
        cyc("lw_decode", 6'b100011, 1, 4'd1);
        cyc("lw_memadr", 6'b100011, 1, 4'd2);
        for (int i = 0; i < 3; i++) cyc("lw_memrd_wait", 6'b100011, 0, 4'd3);
        cyc("lw_memrd_done", 6'b100011, 1, 4'd3);
        cyc("lw_memwb", 6'b100011, 1, 4'd4);
        // beq then addi
        cyc("beq_fetch", 6'b000100, 1, 4'd0);
        cyc("beq_decode", 6'b000100, 1, 4'd1);
        cyc("beq_branch", 6'b000100, 1, 4'd8);
        cyc("addi_fetch", 6'b001000, 1, 4'd0);
        cyc("addi_decode", 6'b001000, 1, 4'd1);
        cyc("addi_ex", 6'b001000, 1, 4'd9);
        cyc("addi_iwb", 6'b001000, 1, 4'd11);
        // FETCH timeout: 15 low cycles then FAULT, sticky
        for (int i = 0; i < 15; i++) cyc("to_fetch_wait", 6'b000000, 0, 4'd0);
        cyc("to_fault", 6'b000000, 0, 4'd14);
        cyc("to_fault_sticky", 6'b000000, 1, 4'd14);
        rst_pulse("fault_rst");
        // ready on the 15th low-window cycle wins over the timeout
        for (int i = 0; i < 14; i++) cyc("nf_fetch_wait", 6'b000010, 0, 4'd0);
        cyc("nf_fetch_ready", 6'b000010, 1, 4'd0);
        cyc("nf_decode", 6'b000010, 1, 4'd1);
        cyc("j_jump", 6'b000010, 1, 4'd12);
        // unsupported opcode
        cyc("ill_fetch", 6'b111111, 1, 4'd0);
        cyc("ill_decode", 6'b111111, 1, 4'd1);
        cyc("ill_state", 6'b111111, 1, 4'd13);
        cyc("ill_sticky", 6'b000000, 1, 4'd13);
        rst_pulse("ill_rst");
        cyc("ill_cleared", 6'b000101, 1, 4'd0);
        cyc("bne_decode", 6'b000101, 1, 4'd1);
`ifdef MC_MAIN_CTRL_BNE_EN
        n_chk++;
        assert (branch_ne === 1'b1) else begin
            n_fail++;
            $error("FAIL bne_flag observed=%b expected=1", branch_ne);
        end
        cyc("bne_branch", 6'b000101, 1, 4'd15);
`else
        cyc("bne_illegal", 6'b000101, 1, 4'd13);
        rst_pulse("bne_rst");
`endif
        // sw: reset lands while MemWrite is asserted
        cyc("sw_fetch", 6'b101011, 1, 4'd0);
        cyc("sw_decode", 6'b101011, 1, 4'd1);
        cyc("sw_memadr", 6'b101011, 1, 4'd2);
        cyc("sw_memwr", 6'b101011, 0, 4'd5);
        rst_pulse("sw_rst");
        cyc("post_rst_fetch", 6'b000000, 1, 4'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
